// File: rtl/pic_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : pic_frame_loader
// Brief    : Assembles a byte stream into RGB565 pixels and writes them to the
//            picture RAM in raster order. Define PIC_LOADER_DBUF_EN for
//            double buffering with bank swap during vertical blanking.
// Revision : 1.0 - initial release
// ============================================================================
module pic_frame_loader #(
    parameter int PIC_SIZE = 156000,
    parameter int ADDR_W   = 19,
    parameter int TIMEOUT  = 50000
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              vblank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              disp_bank,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_SWAP = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_PIC_LAST = ADDR_W'(PIC_SIZE - 1);
    localparam logic [15:0]       C_TO_LAST  = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         timer_q, timer_d;
    logic                bank_q, bank_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   w_base;
    logic                w_swap_go;
    logic                w_bank_next;
    logic [15:0]         w_timer_inc;
    logic                w_timeout;

`ifdef PIC_LOADER_DBUF_EN
    localparam logic [ADDR_W-1:0] C_BANK1_BASE = ADDR_W'(PIC_SIZE);
    // The hidden bank is the one not being displayed.
    assign w_base      = bank_q ? '0 : C_BANK1_BASE;
    assign w_swap_go   = vblank;
    assign w_bank_next = ~bank_q;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_base      = '0;
    assign w_swap_go   = 1'b1;
    assign w_bank_next = 1'b0;
`endif

    assign w_timer_inc = timer_q + 16'd1;
    assign w_timeout   = (w_timer_inc == C_TO_LAST);

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            hi_q      <= '0;
            timer_q   <= '0;
            bank_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            hi_q      <= hi_d;
            timer_q   <= timer_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        hi_d      = hi_q;
        timer_d   = timer_q;
        bank_d    = bank_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fd_d      = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx_valid) begin
                    hi_d      = rx_data;
                    pix_cnt_d = '0;
                    state_d   = S_LO;
                end
            end
            S_LO: begin
                if (rx_valid) begin
                    timer_d   = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_base + pix_cnt_q;
                    wr_data_d = {hi_q, rx_data};
                    if (pix_cnt_q == C_PIC_LAST) begin
                        state_d = S_SWAP;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        state_d   = S_HI;
                    end
                end else if (w_timeout) begin
                    err_d     = 1'b1;
                    timer_d   = '0;
                    pix_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_HI: begin
                if (rx_valid) begin
                    timer_d = '0;
                    hi_d    = rx_data;
                    state_d = S_LO;
                end else if (w_timeout) begin
                    err_d     = 1'b1;
                    timer_d   = '0;
                    pix_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_SWAP: begin
                // Bytes arriving before the swap completes are dropped.
                err_d = rx_valid;
                if (w_swap_go) begin
                    bank_d  = w_bank_next;
                    fd_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign disp_bank  = bank_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_frame_loader
// Brief    : Self-checking bench for pic_frame_loader; byte-count reference
//            model, directed frames followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_frame_loader;

    localparam int PIC = 4;
    localparam int AW  = 4;
    localparam int TO  = 10;
`ifdef PIC_LOADER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic          vga_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          vblank = 1'b0;
    wire           wr_en;
    wire [AW-1:0]  wr_addr;
    wire [15:0]    wr_data;
    wire           disp_bank;
    wire           busy;
    wire           frame_done;
    wire           err;

    pic_frame_loader #(.PIC_SIZE(PIC), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .vblank    (vblank),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .disp_bank (disp_bank),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bytes accepted in the current load and a pending-swap flag.
    int          m_nbytes;
    int          m_idle;
    bit          m_swap;
    bit          m_bank;
    logic [7:0]  m_hi;
    bit          e_wr_en, e_fd, e_err, e_busy;
    logic [31:0] e_addr, e_data;

    logic [7:0] frame_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_nbytes = 0; m_idle = 0; m_swap = 0; m_bank = 0; m_hi = 8'h00;
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_disp_bank", 32'(disp_bank), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    // One clock cycle: drive inputs, advance model, compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit vb);
        int base;
        rx_valid = v; rx_data = d; vblank = vb;
        base = (DBUF && !m_bank) ? PIC : 0;
        e_wr_en = 0; e_fd = 0; e_err = 0;
        if (m_swap) begin
            if (v) e_err = 1;
            if (!DBUF || vb) begin
                if (DBUF) m_bank = !m_bank;
                e_fd = 1;
                m_swap = 0;
            end
        end else if (v) begin
            m_idle = 0;
            m_nbytes++;
            if (m_nbytes % 2 == 1) begin
                m_hi = d;
            end else begin
                e_wr_en = 1;
                e_addr = 32'(base + m_nbytes / 2 - 1);
                e_data = {16'h0, m_hi, d};
                if (m_nbytes == 2 * PIC) begin
                    m_swap = 1;
                    m_nbytes = 0;
                end
            end
        end else if (m_nbytes > 0) begin
            m_idle++;
            if (m_idle == TO - 1) begin
                e_err = 1;
                m_nbytes = 0;
                m_idle = 0;
            end
        end
        e_busy = m_swap || (m_nbytes > 0);

        @(posedge vga_clk);
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_addr", 32'(wr_addr), e_addr);
            chk("wr_data", 32'(wr_data), e_data);
        end
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("err", 32'(err), 32'(e_err));
        chk("disp_bank", 32'(disp_bank), 32'(m_bank));
        chk("busy", 32'(busy), 32'(e_busy));
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) step(1'b1, frame_bytes[i], 1'b0);
    endtask

    task automatic idle(input int n, input bit vb);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, vb);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1 rst = 1'b1;

        // Frame 1, then wait for vblank to swap.
        send_frame();
        idle(4, 1'b0);
        idle(2, 1'b1);
        // Frame 2 lands in the other bank.
        send_frame();
        idle(3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(2, 1'b0);

        // Timeout after three bytes, then restart at pixel 0.
        for (int i = 0; i < 3; i++) step(1'b1, frame_bytes[i], 1'b0);
        idle(12, 1'b0);
        send_frame();
        // Byte dropped while waiting for vblank.
        idle(2, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Byte arriving exactly at the expiry cycle is accepted.
        step(1'b1, 8'h11, 1'b0);
        idle(TO - 2, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        idle(TO + 2, 1'b0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) step(1'b1, frame_bytes[i], 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(posedge vga_clk);
        #1 rst = 1'b1;
        send_frame();
        idle(2, 1'b1);

        // Randomized traffic with varying byte density.
        for (int c = 0; c < 12; c++) begin
            int pct;
            case (c % 4)
                0: pct = 100;
                1: pct = 60;
                2: pct = 20;
                default: pct = 5;
            endcase
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 99) < 15);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_frame_loader.md
# pic_frame_loader

Write-side counterpart to the VGA picture reader: assembles a byte stream (UART receiver output) into RGB565 pixels and writes them into the picture block RAM's write port, in the same raster order the display side reads them. With double buffering it fills the hidden bank and swaps banks only during vertical blanking, so a frame is never shown half-loaded. Runs entirely in the `vga_clk` domain; the byte source is already synchronised into it.

## Interface
- `PIC_SIZE`, 156000, pixels per frame (500 x 312).
- `ADDR_W`, 19, RAM write-address width; must hold 2*PIC_SIZE-1 when double-buffered.
- `TIMEOUT`, 50000, idle cycles mid-frame before the load is aborted; 16-bit counter.

- `vga_clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `rx_data`  in  8  incoming byte; high byte of each pixel first.
- `vblank`  in  1  level, high while the display is in vertical blanking.
- `wr_en`  out  1  RAM write strobe, one cycle per pixel.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  16  RGB565 pixel, {hi_byte, lo_byte}.
- `disp_bank`  out  1  bank the reader displays (0: base 0, 1: base PIC_SIZE).
- `busy`  out  1  high in LO, HI and SWAP.
- `frame_done`  out  1  one-cycle pulse when a completed frame becomes visible.
- `err`  out  1  one-cycle pulse on timeout abort or on a byte dropped in SWAP.

## Operation
- States: IDLE, LO, HI, SWAP.
- IDLE: on `rx_valid`, latch `rx_data` as the high byte, clear `pix_cnt`, go to LO.
- LO: on `rx_valid`, write {hi, rx_data} at `base + pix_cnt`. If `pix_cnt == PIC_SIZE-1`, go to SWAP; otherwise increment `pix_cnt` and go to HI.
- HI: on `rx_valid`, latch the high byte and go to LO.
- SWAP: when `vblank` is high, toggle `disp_bank`, pulse `frame_done`, and go to IDLE. A byte arriving in SWAP is discarded and pulses `err`.
- Write bank is `~disp_bank`; `base` is 0 for bank 0 and PIC_SIZE for bank 1. Address adder is ADDR_W wide, so there is no wrap; `pix_cnt` never exceeds PIC_SIZE-1.
- Timeout: the idle timer clears on every `rx_valid` and on entry to LO or HI. It increments only in LO and HI. When it reaches TIMEOUT-1:
  - pulse `err`, go to IDLE, clear `pix_cnt`;
  - `disp_bank` is unchanged;
  - the partially written hidden bank is simply overwritten by the next load.
- `rx_valid` on the same cycle as a timeout expiry: the byte wins and the timer clears.
- `vblank` already high on entry to SWAP: the swap happens on the next cycle.
- `rst` mid-frame: immediate return to IDLE. Partial RAM contents are left as they are; `disp_bank` returns to 0.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `disp_bank`=0, `busy`=0, `frame_done`=0, `err`=0; state IDLE, `pix_cnt`=0, timer 0.
- All outputs are registered.
- Write latency: a low-byte `rx_valid` in cycle N gives `wr_en`=1 with `wr_addr`/`wr_data` valid in cycle N+1, for exactly one cycle.
- Swap latency: `vblank` sampled high in cycle N while in SWAP gives the `disp_bank` toggle and `frame_done` in cycle N+1.
- `err` is asserted in the cycle after the triggering condition.
- Maximum throughput is one byte per cycle (back-to-back `rx_valid`). The block never back-pressures the source.

## Configuration
- `PIC_LOADER_DBUF_EN` defined: two banks, write bank `~disp_bank`, SWAP waits for `vblank` as described above.
- `PIC_LOADER_DBUF_EN` not defined:
  - single bank; `base` is always 0 and `disp_bank` is tied to 0;
  - SWAP lasts one cycle regardless of `vblank`, pulses `frame_done`, then returns to IDLE;
  - writes may tear the visible image.

## Test plan
- PIC_SIZE=4, DBUF on: 8 bytes 0x12,0x34,...,0xF0 back-to-back -> writes (4,0x1234),(5,0x5678),(6,0x9ABC),(7,0xDEF0) on consecutive odd cycles; `disp_bank` stays 0 until `vblank` rises, then becomes 1 with one `frame_done` pulse.
- Second frame after that -> writes land at addresses 0..3; `disp_bank` returns to 0 at the next `vblank`.
- TIMEOUT=10: 3 bytes, then silence -> `err` pulse exactly 10 cycles after the third byte; next byte is taken as a high byte at `pix_cnt` 0 (address 4 for `disp_bank`=0).
- Byte while in SWAP with `vblank` low -> `err` pulse, no `wr_en`, address sequence unaffected.
- `rst` low mid-frame after 5 bytes -> all outputs at reset values; a fresh 8-byte frame writes addresses 4..7 correctly.
- DBUF off: 8-byte frame -> addresses 0..3, `frame_done` one cycle after the last write, `disp_bank` constant 0.
